// File: rtl/prng_bus_capture.sv
// prng_bus_capture
// Receive-side capture of the gated pseudorandom value bus. Every cycle the
// producer's gate is high, the bus value is queued in a small
// first-word-fall-through FIFO. A downstream consumer drains the FIFO with a
// valid/ready handshake. A sticky overflow flag and a saturating drop counter
// record samples that arrived while the FIFO was full and not being drained.
module prng_bus_capture #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CNTW  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       bus_in,
   input  logic                   bus_en,
   output logic [WIDTH-1:0]       data_out,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow,
   input  logic                   clr_ovf,
   output logic [CNTW-1:0]        drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
   localparam logic [CNTW-1:0] DROP_MAX = '1;

   // Storage and pointers. DEPTH is a power of two, so the pointers wrap
   // naturally when they overflow their PW-bit range.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Per-cycle handshake decisions.
   logic push;
   logic pop;
   logic drop;

   // Status flags are derived purely from the registered occupancy, so they
   // only ever change at a rising edge.
   assign data_valid = (count != '0);
   assign full       = (count == DEPTH_C);

   // Head of FIFO, gated to zero when empty to match the bus convention that
   // an idle bus reads as all-zero.
   assign data_out = mem[rd_ptr] & {WIDTH{data_valid}};

   // Decide whether this cycle pushes, pops or drops the incoming sample.
   // NOTE: every signal written in always_comb is given a default first; a
   // path that leaves one unassigned would infer a latch.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      drop = 1'b0;
      pop  = data_valid & data_ready;
      // A full FIFO still accepts a sample when the head leaves this cycle.
      push = bus_en & (~full | pop);
      drop = bus_en & full & ~pop;
   end

   // Sample storage write; a popped-and-refilled full FIFO writes the slot
   // the read pointer is just leaving, which is safe because the read
   // pointer moves off it at the same edge.
   // NOTE: the storage array is deliberately not reset. Reset empties the
   // FIFO by clearing the pointers and count, and data_out is masked while
   // empty, so stale contents are never visible; leaving the array out of
   // reset lets it map onto plain RAM/register-file cells.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus_in;
      end
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register in this block sees the pre-edge values of the others and the
   // result does not depend on statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Drop statistics. A clear coinciding with a drop still records the new
   // event: overflow stays set and the counter restarts at one.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clr_ovf) begin
         overflow <= drop;
         drop_cnt <= drop ? CNTW'(1) : '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_prng_bus_capture.sv
// tb_prng_bus_capture
// Self-checking bench for prng_bus_capture. A queue-based reference model
// tracks FIFO contents and drop statistics from the behavioural rules;
// directed scenarios cover the documented cases and a randomized run checks
// every output against the model each cycle.
module tb_prng_bus_capture;

   localparam int WIDTH    = 16;
   localparam int DEPTH    = 4;
   localparam int CNTW     = 8;
   localparam int CW       = $clog2(DEPTH) + 1;
   localparam int DROP_MAX = (1 << CNTW) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] bus_in;
   logic             bus_en;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             data_ready;
   logic [CW-1:0]    count;
   logic             full;
   logic             overflow;
   logic             clr_ovf;
   logic [CNTW-1:0]  drop_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   logic [WIDTH-1:0] mq[$];
   bit               m_ovf  = 1'b0;
   int               m_drop = 0;

   prng_bus_capture #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .CNTW (CNTW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_in    (bus_in),
      .bus_en    (bus_en),
      .data_out  (data_out),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .count     (count),
      .full      (full),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // Safety net in case the simulation stalls.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running, need finished");
      $fatal(1);
   end

   function automatic logic [WIDTH-1:0] exp_out();
      return (mq.size() > 0) ? mq[0] : '0;
   endfunction

   task automatic drive(input bit en, input logic [WIDTH-1:0] din, input bit rdy,
                        input bit clr, input bit rst);
      bus_en     = en;
      bus_in     = din;
      data_ready = rdy;
      clr_ovf    = clr;
      reset      = rst;
   endtask

   // Advance one clock: the model decides from the pre-edge inputs and
   // contents, the edge happens, and outputs settle 1 time unit later.
   task automatic tick();
      bit m_pop, m_push, m_dropev;
      m_pop    = (mq.size() > 0) && data_ready;
      m_push   = bus_en && ((mq.size() < DEPTH) || m_pop);
      m_dropev = bus_en && (mq.size() == DEPTH) && !m_pop;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_drop = 0;
      end else begin
         if (m_pop) void'(mq.pop_front());
         if (m_push) mq.push_back(bus_in);
         if (clr_ovf) begin
            m_ovf  = m_dropev;
            m_drop = m_dropev ? 1 : 0;
         end else if (m_dropev) begin
            m_ovf = 1'b1;
            if (m_drop < DROP_MAX) m_drop++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      drive(0, '0, 0, 0, 1);
      tick();
      drive(0, '0, 0, 0, 0);
   endtask

   task automatic test_reset();
      drive(0, 16'hFFFF, 1, 1, 1);
      tick();
      tick();
      drive(0, 16'h0000, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({data_out, data_valid, count, full, overflow, drop_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d: got out=%h valid=%b count=%0d full=%b ovf=%b drops=%0d, need all 0",
                     i, data_out, data_valid, count, full, overflow, drop_cnt);
         end
      end
   endtask

   task automatic test_single_capture();
      do_reset();
      drive(1, 16'hACE1, 0, 0, 0);
      tick();
      drive(0, 16'h0000, 0, 0, 0);
      vectors++;
      if (data_valid !== 1'b1 || data_out !== 16'hACE1 || count !== CW'(1)) begin
         miscompares++;
         $display("FAIL single_capture: got valid=%b out=%h count=%0d, need valid=1 out=ace1 count=1",
                  data_valid, data_out, count);
      end
      tick();
      vectors++;
      if (data_out !== 16'hACE1 || count !== CW'(1)) begin
         miscompares++;
         $display("FAIL single_hold: got out=%h count=%0d, need out=ace1 count=1", data_out, count);
      end
      drive(0, 16'h0000, 1, 0, 0);
      tick();
      drive(0, 16'h0000, 0, 0, 0);
      vectors++;
      if (data_valid !== 1'b0 || data_out !== 16'h0000 || count !== CW'(0)) begin
         miscompares++;
         $display("FAIL single_pop: got valid=%b out=%h count=%0d, need valid=0 out=0000 count=0",
                  data_valid, data_out, count);
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         drive(1, WIDTH'(i), 0, 0, 0);
         tick();
         if (i == 3 || i == 4) begin
            vectors++;
            if (full !== (i == 4) || count !== CW'(i)) begin
               miscompares++;
               $display("FAIL fill_%0d: got full=%b count=%0d, need full=%0d count=%0d",
                        i, full, count, (i == 4), i);
            end
         end
      end
      drive(0, '0, 0, 0, 0);
      vectors++;
      if (overflow !== 1'b1 || drop_cnt !== CNTW'(1) || count !== CW'(4) || data_out !== 16'h0001) begin
         miscompares++;
         $display("FAIL fill_drop: got ovf=%b drops=%0d count=%0d head=%h, need ovf=1 drops=1 count=4 head=0001",
                  overflow, drop_cnt, count, data_out);
      end
      drive(0, '0, 1, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         vectors++;
         if (data_valid !== 1'b1 || data_out !== WIDTH'(i)) begin
            miscompares++;
            $display("FAIL drain_%0d: got valid=%b out=%h, need valid=1 out=%h", i, data_valid, data_out, WIDTH'(i));
         end
         tick();
      end
      drive(0, '0, 0, 0, 0);
      vectors++;
      if (data_valid !== 1'b0 || count !== CW'(0) || full !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_empty: got valid=%b count=%0d full=%b, need 0 0 0", data_valid, count, full);
      end
   endtask

   task automatic test_full_push_pop();
      logic [WIDTH-1:0] exp_seq [4];
      exp_seq = '{16'h0011, 16'h0012, 16'h0013, 16'h00AA};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, WIDTH'(16'h0010 + i), 0, 0, 0);
         tick();
      end
      drive(1, 16'h00AA, 1, 0, 0);
      tick();
      drive(0, '0, 0, 0, 0);
      vectors++;
      if (count !== CW'(4) || full !== 1'b1 || overflow !== 1'b0 || drop_cnt !== CNTW'(0)) begin
         miscompares++;
         $display("FAIL full_push_pop: got count=%0d full=%b ovf=%b drops=%0d, need 4 1 0 0",
                  count, full, overflow, drop_cnt);
      end
      drive(0, '0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (data_out !== exp_seq[i]) begin
            miscompares++;
            $display("FAIL full_pp_order_%0d: got %h, need %h", i, data_out, exp_seq[i]);
         end
         tick();
      end
      drive(0, '0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [15:0] lfsr;
      logic        fb;
      do_reset();
      lfsr = 16'hACE1;
      for (int i = 0; i < 20; i++) begin
         drive(1, lfsr, 1, 0, 0);
         tick();
         vectors++;
         if (data_out !== lfsr || data_valid !== 1'b1 || count !== CW'(1) || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_%0d: got out=%h valid=%b count=%0d ovf=%b, need out=%h valid=1 count=1 ovf=0",
                     i, data_out, data_valid, count, overflow, lfsr);
         end
         fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
         lfsr = {fb, lfsr[15:1]};
      end
      drive(0, '0, 1, 0, 0);
      tick();
      drive(0, '0, 0, 0, 0);
      vectors++;
      if (count !== CW'(0) || data_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stream_end: got count=%0d valid=%b, need 0 0", count, data_valid);
      end
   endtask

   task automatic test_reset_clear();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, WIDTH'(16'h0100 + i), 0, 0, 0);
         tick();
      end
      drive(0, '0, 1, 0, 0);
      tick();
      drive(0, '0, 0, 0, 0);
      vectors++;
      if (count !== CW'(3) || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset: got count=%0d ovf=%b, need count=3 ovf=1", count, overflow);
      end
      drive(1, 16'h5555, 1, 0, 1);
      tick();
      drive(0, '0, 0, 0, 0);
      vectors++;
      if (count !== CW'(0) || overflow !== 1'b0 || data_valid !== 1'b0 || drop_cnt !== CNTW'(0)) begin
         miscompares++;
         $display("FAIL mid_reset: got count=%0d ovf=%b valid=%b drops=%0d, need 0 0 0 0",
                  count, overflow, data_valid, drop_cnt);
      end
      // Fill, drop twice, then drop together with a clear.
      for (int i = 0; i < 6; i++) begin
         drive(1, WIDTH'(16'h0200 + i), 0, 0, 0);
         tick();
      end
      vectors++;
      if (drop_cnt !== CNTW'(2)) begin
         miscompares++;
         $display("FAIL two_drops: got drops=%0d, need 2", drop_cnt);
      end
      drive(1, 16'h0300, 0, 1, 0);
      tick();
      drive(0, '0, 0, 0, 0);
      vectors++;
      if (overflow !== 1'b1 || drop_cnt !== CNTW'(1)) begin
         miscompares++;
         $display("FAIL drop_with_clear: got ovf=%b drops=%0d, need ovf=1 drops=1", overflow, drop_cnt);
      end
      drive(0, '0, 0, 1, 0);
      tick();
      drive(0, '0, 0, 0, 0);
      vectors++;
      if (overflow !== 1'b0 || drop_cnt !== CNTW'(0) || count !== CW'(4)) begin
         miscompares++;
         $display("FAIL plain_clear: got ovf=%b drops=%0d count=%0d, need 0 0 4", overflow, drop_cnt, count);
      end
   endtask

   task automatic test_saturation();
      // FIFO is full from the previous scenario, counter cleared.
      for (int i = 1; i <= 300; i++) begin
         drive(1, WIDTH'($urandom), 0, 0, 0);
         tick();
         if (i == 254 || i == 255 || i == 300) begin
            vectors++;
            if (drop_cnt !== CNTW'((i < DROP_MAX) ? i : DROP_MAX) || overflow !== 1'b1) begin
               miscompares++;
               $display("FAIL saturate_%0d: got drops=%0d ovf=%b, need drops=%0d ovf=1",
                        i, drop_cnt, overflow, (i < DROP_MAX) ? i : DROP_MAX);
            end
         end
      end
      drive(0, '0, 0, 0, 0);
   endtask

   task automatic test_random();
      int errs;
      do_reset();
      errs = 0;
      for (int i = 0; i < 800; i++) begin
         drive(1'($urandom_range(0, 99) < 60), WIDTH'($urandom), 1'($urandom_range(0, 99) < 45),
               1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 199) < 2));
         tick();
         vectors++;
         if (data_out !== exp_out() || data_valid !== 1'(mq.size() > 0) ||
             count !== CW'(mq.size()) || full !== 1'(mq.size() == DEPTH) ||
             overflow !== m_ovf || drop_cnt !== CNTW'(m_drop)) begin
            miscompares++;
            errs++;
            if (errs <= 10)
               $display("FAIL random_%0d: got out=%h valid=%b count=%0d full=%b ovf=%b drops=%0d, need out=%h valid=%0d count=%0d full=%0d ovf=%0d drops=%0d",
                        i, data_out, data_valid, count, full, overflow, drop_cnt,
                        exp_out(), (mq.size() > 0), mq.size(), (mq.size() == DEPTH), m_ovf, m_drop);
         end
      end
      drive(0, '0, 0, 0, 0);
   endtask

   initial begin
      drive(0, '0, 0, 0, 1);
      test_reset();
      test_single_capture();
      test_fill_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_reset_clear();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
